// File: rtl/gpi_pkg.sv
// Shared constants for the GPI interrupt block: CSR bus widths and register offsets.
package gpi_pkg;
  localparam int unsigned CSR_AW = 5;
  localparam int unsigned CSR_DW = 8;

  localparam logic [CSR_AW-1:0] GPI_REG_IN  = 5'd0;
  localparam logic [CSR_AW-1:0] GPI_REG_IE  = 5'd1;
  localparam logic [CSR_AW-1:0] GPI_REG_IP  = 5'd2;
  localparam logic [CSR_AW-1:0] GPI_REG_IEV = 5'd3;
  localparam logic [CSR_AW-1:0] GPI_REG_IBE = 5'd4;
endpackage

// File: rtl/gpi_irq_if.sv
// CPLD CSR bus: 5-bit address, 8-bit data, single-cycle write strobe, registered read data.
interface gpi_irq_if;
  import gpi_pkg::*;

  logic [CSR_AW-1:0] csr_a;
  logic [CSR_DW-1:0] csr_di;
  logic              csr_we;
  logic [CSR_DW-1:0] csr_do;

  modport master (output csr_a, output csr_di, output csr_we, input  csr_do);
  modport slave  (input  csr_a, input  csr_di, input  csr_we, output csr_do);
endinterface

// File: rtl/gpi_filter.sv
// One input bit: two-flop synchroniser, optional debounce, filtered level and same-edge rise/fall strobes.
module gpi_filter #(
  parameter int unsigned DEBOUNCE_CYCLES = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic filt,
  output logic rise_c,
  output logic fall_c
);
  logic s1;
  logic s2;
  logic filt_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      filt <= 1'b0;
    end else begin
      s1   <= in;
      s2   <= s1;
      filt <= filt_nxt;
    end
  end

  if (DEBOUNCE_CYCLES <= 1) begin : g_pass
    assign filt_nxt = s2;
  end else begin : g_debounce
    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [CW-1:0] cnt;

    // Counts consecutive cycles of disagreement; any agreement restarts the count.
    always_ff @(posedge clk) begin
      if (rst) begin
        cnt <= '0;
      end else if (s2 == filt || cnt == LAST) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end

    assign filt_nxt = (s2 != filt && cnt == LAST) ? s2 : filt;
  end

  // Strobes fire combinationally so the pending bit sets on the same edge filt moves.
  assign rise_c = filt_nxt & ~filt;
  assign fall_c = ~filt_nxt & filt;
endmodule

// File: rtl/gpi_irq.sv
// General-purpose input block: per-bit filters, edge-event pending register (W1C) and level irq.
module gpi_irq
  import gpi_pkg::*;
#(
  parameter logic [CSR_AW-1:0] BASE_ADDR       = 5'h00,
  parameter int unsigned       NUM_GPIOS       = 8,
  parameter int unsigned       DEBOUNCE_CYCLES = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  gpi_irq_if.slave             csr,
  input  logic [NUM_GPIOS-1:0] in,
  output logic                 irq
);
  localparam logic [CSR_DW-1:0] MASK = CSR_DW'((33'd1 << NUM_GPIOS) - 33'd1);

  logic [CSR_DW-1:0] filt;
  logic [CSR_DW-1:0] rise_c;
  logic [CSR_DW-1:0] fall_c;
  logic [CSR_DW-1:0] ie;
  logic [CSR_DW-1:0] ip;
  logic [CSR_DW-1:0] iev;
  logic [CSR_DW-1:0] ibe;
  logic [CSR_DW-1:0] ev_c;
  logic [CSR_DW-1:0] w1c_c;
  logic [CSR_DW-1:0] rd_c;
  logic              wr_ie_c;
  logic              wr_ip_c;
  logic              wr_iev_c;
  logic              wr_ibe_c;

  for (genvar i = 0; i < CSR_DW; i++) begin : g_bit
    if (i < NUM_GPIOS) begin : g_used
      gpi_filter #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_filter (
        .clk    (clk),
        .rst    (rst),
        .in     (in[i]),
        .filt   (filt[i]),
        .rise_c (rise_c[i]),
        .fall_c (fall_c[i])
      );
    end else begin : g_unused
      assign filt[i]   = 1'b0;
      assign rise_c[i] = 1'b0;
      assign fall_c[i] = 1'b0;
    end
  end

  assign wr_ie_c  = csr.csr_we && (csr.csr_a == BASE_ADDR + GPI_REG_IE);
  assign wr_ip_c  = csr.csr_we && (csr.csr_a == BASE_ADDR + GPI_REG_IP);
  assign wr_iev_c = csr.csr_we && (csr.csr_a == BASE_ADDR + GPI_REG_IEV);
  assign wr_ibe_c = csr.csr_we && (csr.csr_a == BASE_ADDR + GPI_REG_IBE);

  // IBE selects any edge; otherwise IEV picks rising (1) or falling (0).
  assign ev_c  = ((rise_c & (ibe | iev)) | (fall_c & (ibe | ~iev))) & MASK;
  assign w1c_c = wr_ip_c ? csr.csr_di : '0;

  always_comb begin
    rd_c = '0;
    case (csr.csr_a)
      BASE_ADDR + GPI_REG_IN:  rd_c = filt;
      BASE_ADDR + GPI_REG_IE:  rd_c = ie;
      BASE_ADDR + GPI_REG_IP:  rd_c = ip;
      BASE_ADDR + GPI_REG_IEV: rd_c = iev;
      BASE_ADDR + GPI_REG_IBE: rd_c = ibe;
      default:                 rd_c = '0;
    endcase
  end

  // Set beats clear: a new event is ORed in after the W1C mask is applied.
  always_ff @(posedge clk) begin
    if (rst) begin
      ie         <= '0;
      ip         <= '0;
      iev        <= '0;
      ibe        <= '0;
      irq        <= 1'b0;
      csr.csr_do <= '0;
    end else begin
      if (wr_ie_c)  ie  <= csr.csr_di & MASK;
      if (wr_iev_c) iev <= csr.csr_di & MASK;
      if (wr_ibe_c) ibe <= csr.csr_di & MASK;
      ip         <= ((ip & ~w1c_c) | ev_c) & MASK;
      irq        <= |(ip & ie);
      csr.csr_do <= rd_c;
    end
  end
endmodule

// File: tb/tb_gpi_irq.sv
// Bench for gpi_irq: two configurations on one shared CSR stimulus, checked against a history-based model.
module tb_gpi_irq;
  import gpi_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in;
  logic       irq0;
  logic       irq1;
  logic       rd_req;

  always #5 clk = ~clk;

  gpi_irq_if bus0 ();
  gpi_irq_if bus1 ();

  gpi_irq #(.BASE_ADDR(5'h00), .NUM_GPIOS(8), .DEBOUNCE_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .csr(bus0.slave), .in(in), .irq(irq0));
  gpi_irq #(.BASE_ADDR(5'h10), .NUM_GPIOS(3), .DEBOUNCE_CYCLES(4)) dut1 (
    .clk(clk), .rst(rst), .csr(bus1.slave), .in(in[2:0]), .irq(irq1));

  // Configuration of the two instances as seen by the model
  logic [4:0]  base_a [2] = '{5'h00, 5'h10};
  int unsigned ngpio  [2] = '{8, 3};
  int unsigned ndeb   [2] = '{0, 4};

  logic [7:0] m_filt [2];
  logic [7:0] m_ie   [2];
  logic [7:0] m_ip   [2];
  logic [7:0] m_iev  [2];
  logic [7:0] m_ibe  [2];
  logic       m_irq  [2];
  logic [7:0] hist [$];
  logic [7:0] exp_q0 [$];
  logic [7:0] exp_q1 [$];
  logic       mon_en = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @%0t: got %02h expected %02h", name, $time, act, exp);
  endtask

  function automatic logic [7:0] reg_val(input int d, input logic [4:0] a);
    logic [4:0] off;
    off = a - base_a[d];
    case (off)
      5'd0:    return m_filt[d];
      5'd1:    return m_ie[d];
      5'd2:    return m_ip[d];
      5'd3:    return m_iev[d];
      5'd4:    return m_ibe[d];
      default: return 8'h00;
    endcase
  endfunction

  // Reference model: filt flips once the last max(N,1) synchronised samples all disagree with it.
  always @(posedge clk) begin
    logic [7:0] mask;
    logic [7:0] nf;
    logic [7:0] ev;
    logic [7:0] w1c;
    logic [4:0] a;
    logic [4:0] off;
    logic       flip;
    int         w;
    a = bus0.csr_a;
    if (rst) begin
      for (int d = 0; d < 2; d++) begin
        m_filt[d] = 8'h00; m_ie[d] = 8'h00; m_ip[d] = 8'h00;
        m_iev[d] = 8'h00;  m_ibe[d] = 8'h00; m_irq[d] = 1'b0;
      end
      hist.delete();
      for (int k = 0; k < 8; k++) hist.push_back(8'h00);
      mon_en = 1'b1;
    end else if (mon_en) begin
      hist.push_front(in);
      if (hist.size() > 8) void'(hist.pop_back());
      for (int d = 0; d < 2; d++) begin
        mask = 8'((32'd1 << ngpio[d]) - 32'd1);
        if (rd_req) begin
          if (d == 0) exp_q0.push_back(reg_val(d, a));
          else        exp_q1.push_back(reg_val(d, a));
        end
        w  = (ndeb[d] > 1) ? int'(ndeb[d]) : 1;
        nf = m_filt[d];
        ev = 8'h00;
        for (int b = 0; b < int'(ngpio[d]); b++) begin
          flip = 1'b1;
          for (int k = 2; k <= w + 1; k++)
            if (hist[k][b] == m_filt[d][b]) flip = 1'b0;
          if (flip) begin
            nf[b] = ~m_filt[d][b];
            if (m_ibe[d][b] || (m_iev[d][b] == nf[b])) ev[b] = 1'b1;
          end
        end
        off = a - base_a[d];
        w1c = (bus0.csr_we && off == 5'd2) ? bus0.csr_di : 8'h00;
        m_irq[d] = |(m_ip[d] & m_ie[d]);
        if (bus0.csr_we && off == 5'd1) m_ie[d]  = bus0.csr_di & mask;
        if (bus0.csr_we && off == 5'd3) m_iev[d] = bus0.csr_di & mask;
        if (bus0.csr_we && off == 5'd4) m_ibe[d] = bus0.csr_di & mask;
        m_ip[d]   = ((m_ip[d] & ~w1c) | ev) & mask;
        m_filt[d] = nf;
      end
    end
  end

  // Monitor: compare registered read data whenever a read is outstanding, and irq every cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      if (exp_q0.size() > 0) check("rd_dut0", bus0.csr_do, exp_q0.pop_front());
      if (exp_q1.size() > 0) check("rd_dut1", bus1.csr_do, exp_q1.pop_front());
      check("irq_dut0", {7'b0, irq0}, {7'b0, m_irq[0]});
      check("irq_dut1", {7'b0, irq1}, {7'b0, m_irq[1]});
    end
  end

  task automatic step(input logic [4:0] a, input logic [7:0] di, input logic we, input logic rd);
    bus0.csr_a = a;  bus1.csr_a = a;
    bus0.csr_di = di; bus1.csr_di = di;
    bus0.csr_we = we; bus1.csr_we = we;
    rd_req = rd;
    @(negedge clk);
    bus0.csr_we = 1'b0; bus1.csr_we = 1'b0;
    rd_req = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a);
    step(a, 8'h00, 1'b0, 1'b1);
  endtask

  task automatic wr(input logic [4:0] a, input logic [7:0] di);
    step(a, di, 1'b1, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(5'h1f, 8'h00, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    in  = 8'h00;
    rd_req = 1'b0;
    bus0.csr_a = 5'h1f; bus1.csr_a = 5'h1f;
    bus0.csr_di = 8'h00; bus1.csr_di = 8'h00;
    bus0.csr_we = 1'b0; bus1.csr_we = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state of both register windows plus the first unmapped address
    for (int a = 0; a < 6; a++) rd(5'(a));
    for (int a = 16; a < 22; a++) rd(5'(a));

    // Unfiltered rising event on bit 0 with IE set
    wr(5'h01, 8'h01); wr(5'h03, 8'h01);
    in[0] = 1'b1;
    idle(4);
    rd(5'h00); rd(5'h02); rd(5'h10);

    // Debounce: 3-cycle pulse rejected, 4-cycle pulse accepted
    wr(5'h13, 8'h02);
    in[1] = 1'b1; idle(3); in[1] = 1'b0;
    idle(8); rd(5'h10); rd(5'h12);
    in[1] = 1'b1; idle(4); in[1] = 1'b0;
    idle(2); rd(5'h10); rd(5'h12);
    idle(8); rd(5'h10);

    // Both-edge events on bit 2 with a W1C between them
    wr(5'h04, 8'h04); wr(5'h14, 8'h04);
    in[2] = 1'b1; idle(10); rd(5'h02); rd(5'h12);
    wr(5'h02, 8'h04); wr(5'h12, 8'h04); rd(5'h02); rd(5'h12);
    in[2] = 1'b0; idle(10); rd(5'h02); rd(5'h12);

    // W1C on the same edge as a rising event on bit 3
    wr(5'h01, 8'h09); wr(5'h03, 8'h09); wr(5'h02, 8'hff);
    in[3] = 1'b1;
    idle(2);
    wr(5'h02, 8'h08);
    idle(2); rd(5'h02);

    // Register width clamp and reset during a debounce
    wr(5'h11, 8'hff); rd(5'h11);
    in = 8'h00; idle(10);
    in[0] = 1'b1; idle(3);
    rst = 1'b1; in[0] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int a = 16; a < 21; a++) rd(5'(a));
    idle(10); rd(5'h10); rd(5'h12);

    // Randomised traffic
    for (int i = 0; i < 500; i++) begin
      int op;
      logic [4:0] ra;
      if ($urandom_range(0, 9) == 0) in[$urandom_range(0, 7)] ^= 1'b1;
      op = int'($urandom_range(0, 9));
      ra = 5'($urandom_range(0, 4)) + (($urandom_range(0, 1) == 1) ? 5'h10 : 5'h00);
      if (op < 4)      idle(1);
      else if (op < 7) rd(5'($urandom_range(0, 31)));
      else             wr(ra, 8'($urandom));
    end

    idle(3);
    check("drain_q0", 8'(exp_q0.size()), 8'h00);
    check("drain_q1", 8'(exp_q1.size()), 8'h00);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
